// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encoding, opcode/funct constants, ALU operation codes and datapath mux
// select codes. The HALT state only exists when MIPS_MC_TIMEOUT_EN is defined.
package mips_pkg;

    // Control FSM states; the numeric values are visible on the debug port.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_I_EXEC   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
`ifdef MIPS_MC_TIMEOUT_EN
        , S_HALT   = 4'd14
`endif
    } state_t;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field value for jr (IR[5:0])
    localparam logic [5:0] FN_JR = 6'h08;

    // ALU operation codes understood by the existing ALU
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_SLT   = 5'd4;
    localparam logic [4:0] ALU_LUI   = 5'd5;
    localparam logic [4:0] ALU_RTYPE = 5'd31;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // RegDst selects
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // MemToReg selects
    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // True for the immediate-ALU opcodes that go through I_EXEC
    function automatic logic isIExecOp(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mips_mc_next_state.sv
// Next-state decode for the multi-cycle control FSM. Purely combinational:
// current state plus OpCode/Funct/MemRdy give the following state, and an
// illegal-instruction flag that is only meaningful in DECODE. Timeout
// handling (MIPS_MC_TIMEOUT_EN) is layered on top of this in mips_mc_ctrl.
module mips_mc_next_state
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       MemRdy,
    output state_t     nextState,
    output logic       illegalOp
);

    // Instruction sequencing; memory states hold until MemRdy
    always_comb begin
        nextState = state;
        illegalOp = 1'b0;
        case (state)
            S_FETCH: begin
                if (MemRdy) nextState = S_DECODE;
            end
            S_DECODE: begin
                if (OpCode == OP_RTYPE) begin
                    nextState = (Funct == FN_JR) ? S_JR : S_R_EXEC;
                end else if ((OpCode == OP_LW) || (OpCode == OP_SW)) begin
                    nextState = S_MEM_ADDR;
                end else if ((OpCode == OP_BEQ) || (OpCode == OP_BNE)) begin
                    nextState = S_BRANCH;
                end else if (OpCode == OP_J) begin
                    nextState = S_JUMP;
                end else if (OpCode == OP_JAL) begin
                    nextState = S_JAL;
                end else if (isIExecOp(OpCode)) begin
                    nextState = S_I_EXEC;
                end else begin
                    // Unsupported instruction retires as a NOP
                    nextState = S_FETCH;
                    illegalOp = 1'b1;
                end
            end
            S_R_EXEC:   nextState = S_R_WB;
            S_I_EXEC:   nextState = S_I_WB;
            S_MEM_ADDR: nextState = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (MemRdy) nextState = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (MemRdy) nextState = S_FETCH;
            end
`ifdef MIPS_MC_TIMEOUT_EN
            S_HALT:     nextState = S_HALT;
`endif
            // Write-back, branch and jump states all retire in one cycle
            default:    nextState = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Holds the FSM state register and decodes
// the datapath controls from the current state. Memory accesses use a
// req/rdy handshake: MemReq stays high (with MemWE/IorD steady) until the
// cycle in which MemRdy is seen high; that cycle completes the access.
// Optional build macro MIPS_MC_TIMEOUT_EN adds a wait counter that abandons
// a stalled access after WAIT_MAX cycles, sets sticky BusErr and parks the
// FSM in HALT until reset. Without it BusErr is tied low.
// DbgState exposes the raw state encoding for checkers.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int ALUOP_W  = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemRdy,
    output logic               MemReq,
    output logic               MemWE,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               InstrDone,
    output logic               Illegal,
    output logic               BusErr,
    output logic [3:0]         DbgState
);

    if (2**CNT_W <= WAIT_MAX) begin : gCntWidthCheck
        $error("mips_mc_ctrl: CNT_W too narrow to count to WAIT_MAX");
    end

    state_t state;
    state_t nextState;
    logic   illegalOp;

    mips_mc_next_state uNextState (
        .state     (state),
        .OpCode    (OpCode),
        .Funct     (Funct),
        .MemRdy    (MemRdy),
        .nextState (nextState),
        .illegalOp (illegalOp)
    );

`ifdef MIPS_MC_TIMEOUT_EN
    logic [CNT_W-1:0] waitCnt;
    logic             waiting;
    logic             timeout;
    logic             busErrQ;

    // A stall cycle is any cycle with an outstanding, unanswered request
    assign waiting = MemReq && !MemRdy;
    // The WAIT_MAX-th consecutive stall cycle abandons the access
    assign timeout = waiting && (waitCnt == CNT_W'(WAIT_MAX - 1));

    // State register, wait counter and sticky bus-error flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_FETCH;
            waitCnt <= '0;
            busErrQ <= 1'b0;
        end else if (timeout) begin
            state   <= S_HALT;
            waitCnt <= '0;
            busErrQ <= 1'b1;
        end else begin
            state   <= nextState;
            // Memory states only exit on MemRdy, so clearing whenever we are
            // not stalled also clears on every state change
            waitCnt <= waiting ? (waitCnt + CNT_W'(1)) : '0;
        end
    end

    assign BusErr = busErrQ;
`else
    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    assign BusErr = 1'b0;
`endif

    assign DbgState = state;

    // Moore output decode; only the handshake-completion strobes look at MemRdy
    always_comb begin
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PCSRC_ALU;
        RegWrite  = 1'b0;
        RegDst    = REGDST_RT;
        MemToReg  = MTR_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RT;
        ExtOp     = 1'b0;
        ALUOp     = ALUOP_W'(ALU_ADD);
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                // Instruction read from PC while the ALU forms PC+4
                MemReq  = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemRdy;
                PCWrite = MemRdy;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ALUSrcB = SRCB_IMMSH;
                ExtOp   = 1'b1;
                Illegal = illegalOp;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALU_RTYPE);
            end
            S_R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = REGDST_RD;
                InstrDone = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                // Logical immediates are zero-extended
                ExtOp   = !((OpCode == OP_ANDI) || (OpCode == OP_ORI));
                if (OpCode == OP_SLTI)      ALUOp = ALUOP_W'(ALU_SLT);
                else if (OpCode == OP_ANDI) ALUOp = ALUOP_W'(ALU_AND);
                else if (OpCode == OP_ORI)  ALUOp = ALUOP_W'(ALU_OR);
                else if (OpCode == OP_LUI)  ALUOp = ALUOP_W'(ALU_LUI);
                else                        ALUOp = ALUOP_W'(ALU_ADD);
            end
            S_I_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemToReg  = MTR_MDR;
                InstrDone = 1'b1;
            end
            S_MEM_WR: begin
                MemReq    = 1'b1;
                MemWE     = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemRdy;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_W'(ALU_SUB);
                PCSrc     = PCSRC_ALUOUT;
                PCWrite   = (OpCode == OP_BNE) ? !Zero : Zero;
                InstrDone = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = PCSRC_JUMP;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            S_JAL: begin
                // PC already holds the return address (PC+4) from FETCH
                PCSrc     = PCSRC_JUMP;
                PCWrite   = 1'b1;
                RegWrite  = 1'b1;
                RegDst    = REGDST_RA;
                MemToReg  = MTR_PC;
                InstrDone = 1'b1;
            end
            S_JR: begin
                PCSrc     = PCSRC_RS;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            default: begin
                // HALT: every strobe stays low until reset
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Each instruction is
// described as a list of (expected state, MemRdy) cycles; play() walks the
// list, checks the state every cycle and keeps an output snapshot per cycle
// for the instruction-specific checks that follow.
module tb_mips_mc_ctrl;

    localparam int ALUOP_W = 5;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_R_EXEC   = 4'd2;
    localparam logic [3:0] ST_R_WB     = 4'd3;
    localparam logic [3:0] ST_I_EXEC   = 4'd4;
    localparam logic [3:0] ST_I_WB     = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_MEM_WB   = 4'd8;
    localparam logic [3:0] ST_MEM_WR   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_JAL      = 4'd12;
    localparam logic [3:0] ST_JR       = 4'd13;

    logic               CLK;
    logic               RST;
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic               Zero;
    logic               MemRdy;
    logic               MemReq;
    logic               MemWE;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic [1:0]         PCSrc;
    logic               RegWrite;
    logic [1:0]         RegDst;
    logic [1:0]         MemToReg;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ExtOp;
    logic [ALUOP_W-1:0] ALUOp;
    logic               InstrDone;
    logic               Illegal;
    logic               BusErr;
    logic [3:0]         DbgState;

    mips_mc_ctrl #(.ALUOP_W(ALUOP_W), .WAIT_MAX(15), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .MemRdy(MemRdy), .MemReq(MemReq), .MemWE(MemWE), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp),
        .InstrDone(InstrDone), .Illegal(Illegal), .BusErr(BusErr),
        .DbgState(DbgState)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    typedef struct packed {
        logic [3:0] st;
        logic       memReq;
        logic       memWE;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       regWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       extOp;
        logic [4:0] aluOp;
        logic       instrDone;
        logic       illegal;
        logic       busErr;
    } snap_t;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] expQ[$];
    logic       rdyQ[$];
    snap_t      snapQ[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic snap_t takeSnap();
        snap_t s;
        s.st = DbgState;     s.memReq = MemReq;     s.memWE = MemWE;
        s.iorD = IorD;       s.irWrite = IRWrite;   s.pcWrite = PCWrite;
        s.pcSrc = PCSrc;     s.regWrite = RegWrite; s.regDst = RegDst;
        s.memToReg = MemToReg; s.aluSrcA = ALUSrcA; s.aluSrcB = ALUSrcB;
        s.extOp = ExtOp;     s.aluOp = ALUOp;       s.instrDone = InstrDone;
        s.illegal = Illegal; s.busErr = BusErr;
        return s;
    endfunction

    task automatic pushCyc(input logic [3:0] st, input logic rdy);
        expQ.push_back(st);
        rdyQ.push_back(rdy);
    endtask

    // Starts and ends 1 unit after a rising edge
    task automatic play(input string tag);
        snap_t s;
        logic [3:0] e;
        snapQ.delete();
        while (expQ.size() > 0) begin
            MemRdy = rdyQ.pop_front();
            e = expQ.pop_front();
            @(negedge CLK);
            s = takeSnap();
            snapQ.push_back(s);
            checkEq({tag, ".state"}, 32'(s.st), 32'(e));
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int firstDone();
        for (int i = 0; i < snapQ.size(); i++) begin
            if (snapQ[i].instrDone) return i;
        end
        return -1;
    endfunction

    function automatic int doneCount();
        int n = 0;
        for (int i = 0; i < snapQ.size(); i++) begin
            if (snapQ[i].instrDone) n++;
        end
        return n;
    endfunction

    logic [5:0] iOps[5]  = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
    logic [4:0] iAlu[5]  = '{5'd0, 5'd4, 5'd2, 5'd3, 5'd5};
    logic       iExt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0] bOps[4]  = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       bZero[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       bPcw[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        RST = 1'b0; OpCode = 6'h00; Funct = 6'h00; Zero = 1'b0; MemRdy = 1'b0;
        #2;
        // Reset state: FETCH outputs with MemRdy low
        checkEq("rst.state",   32'(DbgState), 32'(ST_FETCH));
        checkEq("rst.MemReq",  32'(MemReq), 32'd1);
        checkEq("rst.IorD",    32'(IorD), 32'd0);
        checkEq("rst.ALUSrcA", 32'(ALUSrcA), 32'd0);
        checkEq("rst.ALUSrcB", 32'(ALUSrcB), 32'd1);
        checkEq("rst.ALUOp",   32'(ALUOp), 32'd0);
        checkEq("rst.strobes", 32'({MemWE, IRWrite, PCWrite, RegWrite, InstrDone, Illegal}), 32'd0);
        checkEq("rst.BusErr",  32'(BusErr), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // R-type add, zero-wait memory
        OpCode = 6'h00; Funct = 6'h20;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_R_EXEC, 1); pushCyc(ST_R_WB, 1);
        play("add");
        checkEq("add.IRWrite",  32'(snapQ[0].irWrite), 32'd1);
        checkEq("add.PCWrite",  32'(snapQ[0].pcWrite), 32'd1);
        checkEq("add.PCSrc",    32'(snapQ[0].pcSrc), 32'd0);
        checkEq("add.decSrcB",  32'(snapQ[1].aluSrcB), 32'd3);
        checkEq("add.decExt",   32'(snapQ[1].extOp), 32'd1);
        checkEq("add.exSrcA",   32'(snapQ[2].aluSrcA), 32'd1);
        checkEq("add.exSrcB",   32'(snapQ[2].aluSrcB), 32'd0);
        checkEq("add.exAluOp",  32'(snapQ[2].aluOp), 32'd31);
        checkEq("add.RegWrite", 32'(snapQ[3].regWrite), 32'd1);
        checkEq("add.RegDst",   32'(snapQ[3].regDst), 32'd1);
        checkEq("add.MemToReg", 32'(snapQ[3].memToReg), 32'd0);
        checkEq("add.doneAt",   32'(firstDone()), 32'd3);
        checkEq("add.doneCnt",  32'(doneCount()), 32'd1);

        // Immediate ALU ops
        for (int i = 0; i < 5; i++) begin
            OpCode = iOps[i]; Funct = 6'h00;
            pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_I_EXEC, 1); pushCyc(ST_I_WB, 1);
            play("itype");
            checkEq("itype.ALUOp",    32'(snapQ[2].aluOp), 32'(iAlu[i]));
            checkEq("itype.ExtOp",    32'(snapQ[2].extOp), 32'(iExt[i]));
            checkEq("itype.ALUSrcB",  32'(snapQ[2].aluSrcB), 32'd2);
            checkEq("itype.RegWrite", 32'(snapQ[3].regWrite), 32'd1);
            checkEq("itype.RegDst",   32'(snapQ[3].regDst), 32'd0);
            checkEq("itype.doneAt",   32'(firstDone()), 32'd3);
        end

        // lw with 3 fetch wait cycles and 2 data wait cycles; MemRdy low in
        // DECODE/MEM_ADDR where it must be ignored
        OpCode = 6'h23;
        pushCyc(ST_FETCH, 0); pushCyc(ST_FETCH, 0); pushCyc(ST_FETCH, 0); pushCyc(ST_FETCH, 1);
        pushCyc(ST_DECODE, 0); pushCyc(ST_MEM_ADDR, 0);
        pushCyc(ST_MEM_RD, 0); pushCyc(ST_MEM_RD, 0); pushCyc(ST_MEM_RD, 1); pushCyc(ST_MEM_WB, 0);
        play("lw");
        for (int i = 0; i < 4; i++) begin
            checkEq("lw.fReqIorD", 32'({snapQ[i].memReq, snapQ[i].iorD, snapQ[i].memWE}), 32'b100);
            checkEq("lw.IRWrite",  32'(snapQ[i].irWrite), (i == 3) ? 32'd1 : 32'd0);
        end
        checkEq("lw.addrSrcB", 32'(snapQ[5].aluSrcB), 32'd2);
        checkEq("lw.addrExt",  32'(snapQ[5].extOp), 32'd1);
        for (int i = 6; i < 9; i++) begin
            checkEq("lw.rdReqIorD", 32'({snapQ[i].memReq, snapQ[i].iorD, snapQ[i].memWE}), 32'b110);
        end
        checkEq("lw.RegWrite", 32'(snapQ[9].regWrite), 32'd1);
        checkEq("lw.MemToReg", 32'(snapQ[9].memToReg), 32'd1);
        checkEq("lw.doneAt",   32'(firstDone()), 32'd9);

        // sw with one data wait cycle
        OpCode = 6'h2B;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_MEM_ADDR, 1);
        pushCyc(ST_MEM_WR, 0); pushCyc(ST_MEM_WR, 1);
        play("sw");
        checkEq("sw.wait",    32'({snapQ[3].memReq, snapQ[3].memWE, snapQ[3].iorD, snapQ[3].instrDone}), 32'b1110);
        checkEq("sw.rdy",     32'({snapQ[4].memReq, snapQ[4].memWE, snapQ[4].iorD, snapQ[4].instrDone}), 32'b1111);
        checkEq("sw.RegWr",   32'(snapQ[4].regWrite), 32'd0);
        checkEq("sw.doneCnt", 32'(doneCount()), 32'd1);

        // beq/bne with both Zero values
        for (int i = 0; i < 4; i++) begin
            OpCode = bOps[i]; Zero = bZero[i];
            pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_BRANCH, 1);
            play("br");
            checkEq("br.PCWrite", 32'(snapQ[2].pcWrite), 32'(bPcw[i]));
            checkEq("br.PCSrc",   32'(snapQ[2].pcSrc), 32'd1);
            checkEq("br.ALUOp",   32'(snapQ[2].aluOp), 32'd1);
            checkEq("br.doneAt",  32'(firstDone()), 32'd2);
        end
        Zero = 1'b0;

        // j
        OpCode = 6'h02;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_JUMP, 1);
        play("j");
        checkEq("j.ctl", 32'({snapQ[2].pcWrite, snapQ[2].pcSrc, snapQ[2].regWrite, snapQ[2].instrDone}), 32'b11001);

        // jal
        OpCode = 6'h03;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_JAL, 1);
        play("jal");
        checkEq("jal.PCWrite",  32'(snapQ[2].pcWrite), 32'd1);
        checkEq("jal.PCSrc",    32'(snapQ[2].pcSrc), 32'd2);
        checkEq("jal.RegWrite", 32'(snapQ[2].regWrite), 32'd1);
        checkEq("jal.RegDst",   32'(snapQ[2].regDst), 32'd2);
        checkEq("jal.MemToReg", 32'(snapQ[2].memToReg), 32'd2);
        checkEq("jal.doneAt",   32'(firstDone()), 32'd2);

        // jr
        OpCode = 6'h00; Funct = 6'h08;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_JR, 1);
        play("jr");
        checkEq("jr.ctl", 32'({snapQ[2].pcWrite, snapQ[2].pcSrc, snapQ[2].instrDone}), 32'b1111);

        // Unsupported opcode: Illegal pulse in DECODE, straight back to FETCH
        OpCode = 6'h3F; Funct = 6'h00;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_FETCH, 0);
        play("ill");
        checkEq("ill.fetch",   32'(snapQ[0].illegal), 32'd0);
        checkEq("ill.Illegal", 32'(snapQ[1].illegal), 32'd1);
        checkEq("ill.writes",  32'({snapQ[1].regWrite, snapQ[1].pcWrite}), 32'd0);
        checkEq("ill.after",   32'(snapQ[2].illegal), 32'd0);
        checkEq("ill.doneCnt", 32'(doneCount()), 32'd0);

        // Reset asserted in the middle of a stalled store
        OpCode = 6'h2B;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_MEM_ADDR, 1);
        pushCyc(ST_MEM_WR, 0); pushCyc(ST_MEM_WR, 0);
        play("swrst");
        checkEq("swrst.MemWE", 32'(snapQ[4].memWE), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        checkEq("swrst.state",  32'(DbgState), 32'(ST_FETCH));
        checkEq("swrst.mem",    32'({MemReq, MemWE, IorD}), 32'b100);
        checkEq("swrst.writes", 32'({InstrDone, PCWrite, RegWrite, IRWrite}), 32'd0);
        checkEq("swrst.BusErr", 32'(BusErr), 32'd0);
        checkEq("swrst.doneCnt", 32'(doneCount()), 32'd0);
        @(posedge CLK);
        #1;
        checkEq("swrst.hold", 32'(DbgState), 32'(ST_FETCH));
        RST = 1'b1;

`ifdef MIPS_MC_TIMEOUT_EN
        // Fetch that never completes: 15 stall cycles then HALT
        OpCode = 6'h00; Funct = 6'h20;
        for (int i = 0; i < 15; i++) pushCyc(ST_FETCH, 0);
        pushCyc(4'd14, 1); pushCyc(4'd14, 0); pushCyc(4'd14, 1);
        play("tmo");
        checkEq("tmo.beforeErr", 32'(snapQ[14].busErr), 32'd0);
        for (int i = 15; i < 18; i++) begin
            checkEq("tmo.BusErr",  32'(snapQ[i].busErr), 32'd1);
            checkEq("tmo.strobes", 32'({snapQ[i].memReq, snapQ[i].memWE, snapQ[i].irWrite,
                                        snapQ[i].pcWrite, snapQ[i].regWrite, snapQ[i].instrDone}), 32'd0);
        end
        RST = 1'b0;
        #1;
        checkEq("tmo.rstState",  32'(DbgState), 32'(ST_FETCH));
        checkEq("tmo.rstBusErr", 32'(BusErr), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
`endif

        // Normal operation after reset release
        OpCode = 6'h00; Funct = 6'h20;
        pushCyc(ST_FETCH, 1); pushCyc(ST_DECODE, 1); pushCyc(ST_R_EXEC, 1); pushCyc(ST_R_WB, 1);
        play("post");
        checkEq("post.doneAt", 32'(firstDone()), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
